// File: rtl/vga_clock_timing.sv
// 640x480 VGA timing: 25 MHz pixel clock, 1 Hz slow clock, raster counters with combinational sync/de/frame.
// Single-cycle registered counters; decode has zero latency from sx/sy; no backpressure (free-running).
module vga_clock_timing #(
  parameter int SLOW_HALF_PERIOD = 25_000_000,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clock_50M,
  input  logic       reset_n,
  output logic       clock_25M,
  output logic       pix_en,
  output logic       clock_1Hz,
  output logic [9:0] sx,
  output logic [9:0] sy,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       frame
);

  localparam logic [24:0] SLOW_LAST = 25'(SLOW_HALF_PERIOD - 1);
  localparam logic [9:0] H_DE_END   = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_LST = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_DE_END   = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_LST = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic        clk25_q, clk25_d;
  logic        clk1_q, clk1_d;
  logic [24:0] cnt_q, cnt_d;
  logic [9:0]  sx_q, sx_d;
  logic [9:0]  sy_q, sy_d;

  always_comb begin
    clk25_d = ~clk25_q;
    clk1_d  = clk1_q;
    cnt_d   = cnt_q + 25'd1;
    if (cnt_q == SLOW_LAST) begin
      cnt_d  = '0;
      clk1_d = ~clk1_q;
    end

    sx_d = sx_q;
    sy_d = sy_q;
    // Raster advances only on the 50 MHz edge where the pixel clock is about to fall.
    if (clk25_q) begin
      if (sx_q == H_LAST) begin
        sx_d = '0;
        sy_d = (sy_q == V_LAST) ? 10'd0 : sy_q + 10'd1;
      end else begin
        sx_d = sx_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clock_50M) begin
    if (!reset_n) begin
      clk25_q <= 1'b0;
      clk1_q  <= 1'b0;
      cnt_q   <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
    end else begin
      clk25_q <= clk25_d;
      clk1_q  <= clk1_d;
      cnt_q   <= cnt_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
    end
  end

  assign clock_25M = clk25_q;
  assign pix_en    = clk25_q;
  assign clock_1Hz = clk1_q;
  assign sx        = sx_q;
  assign sy        = sy_q;

  assign de    = (sx_q < H_DE_END) && (sy_q < V_DE_END);
  assign hsync = !((sx_q >= H_SYNC_BEG) && (sx_q <= H_SYNC_LST));
  assign vsync = !((sy_q >= V_SYNC_BEG) && (sy_q <= V_SYNC_LST));
  assign frame = (sy_q == V_DE_END) && (sx_q == 10'd0);

endmodule

// File: tb/tb_vga_clock_timing.sv
// Directed/random bench for vga_clock_timing with a reduced raster and an arithmetic timing model.
module tb_vga_clock_timing;

  localparam int SHP = 4;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 6, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME_CYC = HT * VT * 2;

  logic       clock_50M = 1'b0;
  logic       reset_n = 1'b0;
  logic       clock_25M, pix_en, clock_1Hz, hsync, vsync, de, frame;
  logic [9:0] sx, sy;

  int n_pass = 0;
  int n_checks = 0;
  int t = 0;

  vga_clock_timing #(
    .SLOW_HALF_PERIOD(SHP),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clock_50M(clock_50M), .reset_n(reset_n),
    .clock_25M(clock_25M), .pix_en(pix_en), .clock_1Hz(clock_1Hz),
    .sx(sx), .sy(sy), .hsync(hsync), .vsync(vsync), .de(de), .frame(frame)
  );

  always #10 clock_50M = ~clock_50M;

  // Model: t = edges since reset release; the pixel index is t/2.
  function automatic int m_sx(); return (t / 2) % HT; endfunction
  function automatic int m_sy(); return ((t / 2) / HT) % VT; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
  endtask

  task automatic check_all();
    int ex, ey;
    ex = m_sx();
    ey = m_sy();
    chk("clock_25M", 32'(clock_25M), 32'(t % 2));
    chk("pix_en",    32'(pix_en),    32'(t % 2));
    chk("clock_1Hz", 32'(clock_1Hz), 32'((t / SHP) % 2));
    chk("sx", 32'(sx), 32'(ex));
    chk("sy", 32'(sy), 32'(ey));
    chk("de",    32'(de),    32'(ex < HA && ey < VA));
    chk("hsync", 32'(hsync), 32'(!(ex >= HA + HF && ex < HA + HF + HS)));
    chk("vsync", 32'(vsync), 32'(!(ey >= VA + VF && ey < VA + VF + VS)));
    chk("frame", 32'(frame), 32'(ey == VA && ex == 0));
  endtask

  task automatic tick(input logic rn);
    reset_n = rn;
    @(posedge clock_50M);
    t = rn ? t + 1 : 0;
    #1;
    check_all();
  endtask

  initial begin
    int n_frame_hi, n_hs_lo, n_vs_lo, n_de_hi, rise1, rise2, guard;
    logic prev_frame;

    // Reset held, then reset again from a mid-line position.
    repeat (4) tick(1'b0);
    repeat (30 + $urandom_range(0, 20)) tick(1'b1);
    repeat (4) tick(1'b0);
    chk("rst_sx", 32'(sx), 32'd0);
    chk("rst_de_hs_vs", {29'd0, de, hsync, vsync}, 32'd7);

    // Two full frames from release: pixel clock, line and frame timing.
    n_frame_hi = 0; n_hs_lo = 0; n_vs_lo = 0; n_de_hi = 0;
    rise1 = -1; rise2 = -1; prev_frame = 1'b0;
    for (int i = 1; i <= 2 * FRAME_CYC; i++) begin
      tick(1'b1);
      n_frame_hi += int'(frame);
      n_hs_lo    += int'(!hsync);
      n_vs_lo    += int'(!vsync);
      n_de_hi    += int'(de);
      if (frame && !prev_frame) begin
        if (rise1 < 0) rise1 = i;
        else if (rise2 < 0) rise2 = i;
      end
      prev_frame = frame;
    end
    chk("frame_hi_cycles", 32'(n_frame_hi), 32'd4);
    chk("frame_period", 32'(rise2 - rise1), 32'(FRAME_CYC));
    chk("hsync_lo_cycles", 32'(n_hs_lo), 32'(2 * VT * HS * 2));
    chk("vsync_lo_cycles", 32'(n_vs_lo), 32'(2 * VS * HT * 2));
    chk("de_hi_cycles", 32'(n_de_hi), 32'(2 * VA * HA * 2));
    chk("wrap_to_origin", {22'd0, sx} | {6'd0, sy, 16'd0}, 32'd0);

    // Random-length runs each ended by a single-cycle reset pulse.
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(1, 500)) tick(1'b1);
      tick(1'b0);
    end

    // Reset in the vsync rows, then resume.
    guard = 0;
    while (m_sy() != VA + VF && guard < 2 * FRAME_CYC) begin
      tick(1'b1);
      guard++;
    end
    chk("reach_vsync_row", 32'(guard < 2 * FRAME_CYC), 32'd1);
    tick(1'b0);
    repeat (20) tick(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_clock_timing.md
# vga_clock_timing

Clock-generation and VGA raster-timing block for the 640x480@60 Hz display path. From the 50 MHz board clock it produces a 25 MHz pixel clock for the VGA DAC, a slow 1 Hz tick clock for user-input polling, and the horizontal/vertical pixel counters with sync, display-enable and frame-start signals. The pixel painter reads `sx`/`sy`/`de` from this block to drive the DAC outputs.

## Interface
- `SLOW_HALF_PERIOD`, default 25_000_000: `clock_50M` cycles per half period of `clock_1Hz`. Benches override it with a small value.
- `H_ACTIVE` 640, `H_FP` 16, `H_SYNC` 96, `H_BP` 48: horizontal timing in pixels. Line total is 800.
- `V_ACTIVE` 480, `V_FP` 10, `V_SYNC` 2, `V_BP` 33: vertical timing in lines. Frame total is 525.
- `clock_50M`  in  1: the only clock. All state updates on its rising edge.
- `reset_n`  in  1: reset, synchronous and active-low.
- `clock_25M`  out  1: pixel clock, `clock_50M`/2. Registered.
- `pix_en`  out  1: pixel-advance enable, equal to `clock_25M` (high on the 50 MHz cycle before `clock_25M` falls).
- `clock_1Hz`  out  1: slow square wave. Registered.
- `sx`  out  10: horizontal pixel counter, 0..799.
- `sy`  out  10: vertical line counter, 0..524.
- `hsync`  out  1: horizontal sync, active-low.
- `vsync`  out  1: vertical sync, active-low.
- `de`  out  1: display enable, high in the visible area.
- `frame`  out  1: high for one pixel period at the start of vertical blanking.

## Operation
- **25 MHz divider:** `clock_25M` toggles on every `clock_50M` edge when out of reset.
- **1 Hz divider:**
  - A 25-bit counter `cnt` counts 0..`SLOW_HALF_PERIOD`-1.
  - When `cnt` = `SLOW_HALF_PERIOD`-1: `cnt` returns to 0 and `clock_1Hz` toggles.
  - Full period is 2×`SLOW_HALF_PERIOD` cycles with a 50% duty cycle.
- **Raster counters:** update only on edges where `pix_en`=1.
  - `sx` increments each such edge.
  - At `sx`=799, `sx` wraps to 0 and `sy` increments.
  - At `sx`=799 and `sy`=524, both wrap to 0.
- **Decoded outputs:** purely combinational from the registered `sx`/`sy`.
  - `de` = (`sx` < 640) && (`sy` < 480).
  - `hsync` = !(656 ≤ `sx` ≤ 751).
  - `vsync` = !(490 ≤ `sy` ≤ 491).
  - `frame` = (`sy` = 480) && (`sx` = 0).
- **Widths:** `sx`/`sy` are 10-bit unsigned. All comparisons are unsigned. No counter ever reaches its total value.

## Timing
- **Reset values** (applied at the first `clock_50M` edge with `reset_n`=0):
  - `clock_25M`=0, `pix_en`=0, `clock_1Hz`=0, `cnt`=0, `sx`=0, `sy`=0.
  - Decoded outputs therefore read `de`=1, `hsync`=1, `vsync`=1, `frame`=0.
- **After release:**
  - `clock_25M` is 1 after the first edge and alternates 0/1 on every edge after that.
  - `sx` first becomes 1 on the second edge after release.
  - Each `sx` value holds for exactly 2 `clock_50M` cycles, so `frame` is high for 2 cycles.
- **Sync latency:** zero relative to the counters, because the decode is combinational.
- **Frame period:** 800×525×2 = 840,000 `clock_50M` cycles.
- **Reset mid-operation:** all counters and clocks return to their reset values on the next edge, regardless of counter position. The 1 Hz and pixel dividers restart phase-aligned.
- **`reset_n` held low:** outputs stay frozen at their reset values.

## Test plan
- **Reset:** hold `reset_n`=0 for 4 cycles with counters mid-line (`sx`≈300) -> `sx`=`sy`=0, `clock_25M`=0, `clock_1Hz`=0, `de`=1, `hsync`=`vsync`=1.
- **Pixel clock:** release reset and run 10 cycles -> `clock_25M` reads 1,0,1,0…; `sx` goes 0,0,1,1,2,2…
- **Line timing:** run one full line -> `de` falls at `sx`=640; `hsync` low for `sx` 656..751 (192 `clock_50M` cycles); `sx` wraps 799->0 and `sy` goes 0->1.
- **Frame timing:** run a full frame -> `frame` high 2 cycles at (`sx`=0, `sy`=480); `vsync` low for `sy` 490..491; (799,524) wraps to (0,0); total 840,000 cycles.
- **Slow clock:** with `SLOW_HALF_PERIOD`=4 -> `clock_1Hz` toggles every 4 cycles (period 8); the counter wraps 3->0 exactly on each toggle.
- **Mid-frame reset:** assert `reset_n`=0 for 1 cycle at `sy`=300 -> the next edge gives `sx`=`sy`=0; normal counting resumes on the following edges.
